// File: rtl/frame_shape_analyzer.sv
// Frame analysis engine: scans one RGB frame from the frame buffer and reports
// dominant colour, shape class, bounding box and lit-pixel count.
module frame_shape_analyzer #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int AW      = 15,
  parameter int CW      = 4,
  parameter int RD_LAT  = 1,
  parameter int MIN_LVL = 1,
  parameter int MIN_RUN = 3,
  parameter int ACC_W   = 20
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic [AW-1:0]                        mem_addr,
  input  logic [3*CW-1:0]                      mem_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [1:0]                           color,
  output logic [1:0]                           figure,
  output logic [$clog2(WIDTH)-1:0]             bbox_x0,
  output logic [$clog2(WIDTH)-1:0]             bbox_x1,
  output logic [$clog2(HEIGHT)-1:0]            bbox_y0,
  output logic [$clog2(HEIGHT)-1:0]            bbox_y1,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    pixel_count,
  output logic [2:0]                           dbg_state
);
  localparam int N   = WIDTH * HEIGHT;
  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int PW  = $clog2(N + 1);
  localparam int RWW = $clog2(WIDTH + 1);
  localparam int VW  = $clog2(HEIGHT + 1);
  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0]  A_LAST = AW'(N - 1);
  localparam logic [XW-1:0]  X_LAST = XW'(WIDTH - 1);
  localparam logic [CW-1:0]  L_MIN  = CW'(MIN_LVL);
  localparam logic [RWW-1:0] L_RUN  = RWW'(MIN_RUN);
  localparam logic [DCW-1:0] D_LAST = DCW'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_CLASSIFY, S_DONE} state_t;
  state_t r_state, w_next;

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [DCW-1:0]   r_drain;
  logic [ACC_W-1:0] r_sum_r, r_sum_g, r_sum_b;
  logic [RWW-1:0]   r_row_w, r_prev_w;
  logic [VW-1:0]    r_valid, r_grow;
  logic             r_tv [RD_LAT];
  logic [XW-1:0]    r_tx [RD_LAT];
  logic [YW-1:0]    r_ty [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_SCAN;
      S_SCAN:     if (mem_addr == A_LAST) w_next = S_DRAIN;
      S_DRAIN:    if (r_drain == D_LAST) w_next = S_CLASSIFY;
      S_CLASSIFY: w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state == S_SCAN) || (r_state == S_DRAIN) || (r_state == S_CLASSIFY);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  // Tag stage 0 describes the address currently on mem_addr; the last stage lines up with mem_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        r_tv[k] <= 1'b0;
        r_tx[k] <= '0;
        r_ty[k] <= '0;
      end
    end else begin
      r_tv[0] <= (r_state == S_SCAN);
      r_tx[0] <= r_x;
      r_ty[0] <= r_y;
      for (int k = 1; k < RD_LAT; k++) begin
        r_tv[k] <= r_tv[k-1];
        r_tx[k] <= r_tx[k-1];
        r_ty[k] <= r_ty[k-1];
      end
    end
  end

  logic           w_tv, w_eol, w_lit;
  logic [XW-1:0]  w_tx;
  logic [YW-1:0]  w_ty;
  logic [CW-1:0]  w_cr, w_cg, w_cb;
  logic [RWW-1:0] w_row_w;

  assign w_tv    = r_tv[RD_LAT-1];
  assign w_tx    = r_tx[RD_LAT-1];
  assign w_ty    = r_ty[RD_LAT-1];
  assign w_eol   = (w_tx == X_LAST);
  assign w_cr    = mem_data[3*CW-1:2*CW];
  assign w_cg    = mem_data[2*CW-1:CW];
  assign w_cb    = mem_data[CW-1:0];
  assign w_lit   = w_tv && ((w_cr >= L_MIN) || (w_cg >= L_MIN) || (w_cb >= L_MIN));
  assign w_row_w = r_row_w + RWW'(w_lit);

  logic [1:0]  w_color, w_figure;
  logic [VW:0] w_v, w_g, w_q, w_vmq, w_vpq;

  assign w_v   = {1'b0, r_valid};
  assign w_g   = {1'b0, r_grow};
  assign w_q   = w_v >> 2;
  assign w_vmq = w_v - w_q;
  assign w_vpq = w_v + w_q;

  always_comb begin
    w_color = 2'd0;
    if (r_sum_r > r_sum_g && r_sum_r > r_sum_b)      w_color = 2'd1;
    else if (r_sum_g > r_sum_r && r_sum_g > r_sum_b) w_color = 2'd2;
    else if (r_sum_b > r_sum_r && r_sum_b > r_sum_g) w_color = 2'd3;
    w_figure = 2'd0;
    if (w_g <= w_v && w_g > w_vmq)                   w_figure = 2'd1;
    else if (w_g > (w_vmq >> 1) && w_g < (w_vpq >> 1)) w_figure = 2'd2;
    else if (w_v != '0)                              w_figure = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_drain     <= '0;
      r_sum_r     <= '0;
      r_sum_g     <= '0;
      r_sum_b     <= '0;
      r_row_w     <= '0;
      r_prev_w    <= '0;
      r_valid     <= '0;
      r_grow      <= '0;
      pixel_count <= '0;
      bbox_x0     <= '0;
      bbox_x1     <= '0;
      bbox_y0     <= '0;
      bbox_y1     <= '0;
      color       <= 2'd0;
      figure      <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          mem_addr    <= '0;
          r_x         <= '0;
          r_y         <= '0;
          r_sum_r     <= '0;
          r_sum_g     <= '0;
          r_sum_b     <= '0;
          r_row_w     <= '0;
          r_prev_w    <= '0;
          r_valid     <= '0;
          r_grow      <= '0;
          pixel_count <= '0;
          bbox_x0     <= '0;
          bbox_x1     <= '0;
          bbox_y0     <= '0;
          bbox_y1     <= '0;
          color       <= 2'd0;
          figure      <= 2'd0;
        end
        S_SCAN: begin
          r_drain <= '0;
          if (mem_addr != A_LAST) begin
            mem_addr <= mem_addr + AW'(1);
            if (r_x == X_LAST) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
            end else begin
              r_x <= r_x + XW'(1);
            end
          end
        end
        S_DRAIN: r_drain <= r_drain + DCW'(1);
        S_CLASSIFY: begin
          // An empty frame reports nothing at all, whatever the row counters say.
          color  <= (pixel_count == '0) ? 2'd0 : w_color;
          figure <= (pixel_count == '0) ? 2'd0 : w_figure;
        end
        default: ;
      endcase

      if (w_lit) begin
        r_sum_r     <= r_sum_r + ACC_W'(w_cr);
        r_sum_g     <= r_sum_g + ACC_W'(w_cg);
        r_sum_b     <= r_sum_b + ACC_W'(w_cb);
        pixel_count <= pixel_count + PW'(1);
        if (pixel_count == '0) begin
          bbox_x0 <= w_tx;
          bbox_x1 <= w_tx;
          bbox_y0 <= w_ty;
          bbox_y1 <= w_ty;
        end else begin
          if (w_tx < bbox_x0) bbox_x0 <= w_tx;
          if (w_tx > bbox_x1) bbox_x1 <= w_tx;
          if (w_ty < bbox_y0) bbox_y0 <= w_ty;
          if (w_ty > bbox_y1) bbox_y1 <= w_ty;
        end
      end

      if (w_tv) begin
        if (w_eol) begin
          if (w_row_w > L_RUN) begin
            r_valid <= r_valid + VW'(1);
            if (w_row_w > r_prev_w) r_grow <= r_grow + VW'(1);
          end
          r_prev_w <= w_row_w;
          r_row_w  <= '0;
        end else begin
          r_row_w <= w_row_w;
        end
      end
    end
  end
endmodule

// File: doc/frame_shape_analyzer.md
Name: frame_shape_analyzer

Overview:
Post-capture analysis engine that scans one RGB frame stored in the camera frame buffer and reports dominant colour, shape class, bounding box and lit-pixel count. It is the parametrised successor of the fixed 160x120 processing block. It adds configurable frame size, channel depth, memory read latency and thresholds, plus bounding-box and pixel-count outputs. It sits between the frame-buffer read port and the SoC CSR bank, and runs single-clock on posedge only.

Parameters:
WIDTH, 160, pixels per row
HEIGHT, 120, rows per frame
AW, 15, frame-buffer address width; must satisfy 2^AW >= WIDTH*HEIGHT
CW, 4, bits per colour channel; pixel word DW = 3*CW laid out as {R,G,B}
RD_LAT, 1, frame-buffer read latency in cycles (1..4)
MIN_LVL, 1, a pixel is lit when any channel >= MIN_LVL
MIN_RUN, 3, a row is valid when its lit count > MIN_RUN
ACC_W, 20, colour accumulator width; must satisfy ACC_W >= CW + clog2(WIDTH*HEIGHT), so no saturation logic is needed

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  level or pulse; sampled only in IDLE
mem_addr  out  AW  frame-buffer read address
mem_data  in  3*CW  pixel returned RD_LAT cycles after mem_addr
busy  out  1  high while a frame is being processed
done  out  1  one-cycle pulse; results valid from this cycle onward
color  out  2  0 none/tie, 1 red, 2 green, 3 blue
figure  out  2  0 none, 1 triangle, 2 circle, 3 square
bbox_x0, bbox_x1  out  clog2(WIDTH) each  min/max column of lit pixels
bbox_y0, bbox_y1  out  clog2(HEIGHT) each  min/max row of lit pixels
pixel_count  out  clog2(WIDTH*HEIGHT+1)  number of lit pixels

Behaviour:
- Reset: state=IDLE. All outputs 0 (mem_addr, busy, done, color, figure, bbox, pixel_count). Accumulators and counters 0. Reset during any state aborts the scan and is complete in one cycle.
- FSM states: IDLE -> SCAN -> DRAIN -> CLASSIFY -> DONE -> IDLE.
- IDLE: start=1 at cycle 0 clears all accumulators, counters and the previous results, sets busy=1 and enters SCAN.
- SCAN: issues one address per cycle, 0..N-1 where N=WIDTH*HEIGHT, in row-major order (addr = y*WIDTH+x). The x/y counters wrap x at WIDTH-1. After addr N-1 the FSM enters DRAIN.
- Tag pipeline: a valid/x/y/end-of-row tag travels with each address through an RD_LAT-deep shift register. mem_data is processed only when its tag is valid.
- Per valid pixel, when lit:
  - R/G/B sums += channel values.
  - row_width++ and pixel_count++.
  - Update bbox min/max. The first lit pixel initialises all four bbox values.
- End of row (tag x == WIDTH-1, after that pixel is counted):
  - If row_width > MIN_RUN: valid_rows++. If additionally row_width > prev_width: grow_rows++.
  - Then prev_width <= row_width and row_width <= 0. prev_width starts at 0 for each frame.
- DRAIN: lasts exactly RD_LAT cycles, until the last tag retires.
- CLASSIFY: one cycle.
  - Colour: strictly largest sum wins; any tie for the maximum gives 0.
  - Figure uses integer floor arithmetic with V=valid_rows, G=grow_rows, q=V>>2:
    - triangle if G <= V and G > V-q
    - else circle if G > (V-q)>>1 and G < (V+q)>>1
    - else square if V > 0
    - else 0
  - If pixel_count == 0: color=0, figure=0, bbox all 0.
- DONE: done=1 for one cycle; busy drops to 0 in the same cycle that done rises; return to IDLE.
- Latency: done is asserted exactly at cycle N+RD_LAT+2 after the start cycle. busy=1 during cycles 1..N+RD_LAT+1.
- start while busy or in DONE is ignored. start held high re-triggers a new frame the cycle after DONE.
- Outputs hold their values until the next accepted start or reset. mem_addr holds its last value when not scanning.

Test Plan:
1. WIDTH=16, HEIGHT=12, RD_LAT=1, all-black frame, start pulse -> done at cycle 195, color=0, figure=0, pixel_count=0, bbox=0.
2. Same size, red 0xF00 8x8 block at x4..11, y2..9 -> color=1, figure=3 (V=8, G=1), bbox 4/11/2/9, pixel_count=64.
3. Green 0x0F0 rows y0..7 with widths 4,5,...,11 -> V=8, G=8, figure=1, color=2, pixel_count=60.
4. Blue rows with widths 4,6,8,10,10,8,6,4 -> V=8, G=4, figure=2, color=3; equal R and G sums with B=0 -> color=0.
5. RD_LAT=3 rerun of scenario 2 -> identical results, done at cycle 197; start pulsed at cycle 50 is ignored and done is not retriggered.
6. rst asserted at cycle 100 of a scan -> next cycle busy=0 and all outputs 0; a fresh start then reproduces scenario 2 results exactly.
